// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline hazard control: load-use stall, MEM redirect flush, data-memory wait with timeout
module pipe_hazard_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic [2:0]       mem_npc_op,
    input  logic             mem_zero,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_write,
    output logic             ex_mem_write,
    output logic             mem_wb_write,
    output logic             IFflush,
    output logic             IDflush,
    output logic             EXflush,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] redirect_cnt
);
    localparam logic [2:0]       NPC_BRANCH = 3'd1;
    localparam logic [2:0]       NPC_JUMP   = 3'd2;
    localparam logic [2:0]       NPC_JALR   = 3'd3;
    localparam logic [15:0]      WCNT_LIMIT = 16'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      wcnt_q, wcnt_d;
    logic             mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] redirect_cnt_q, redirect_cnt_d;
    logic             redirect, load_use, mem_busy, advance;

    assign redirect = ((mem_npc_op == NPC_BRANCH) && mem_zero) ||
                      (mem_npc_op == NPC_JUMP) || (mem_npc_op == NPC_JALR);
    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((id_use_rs1 && (ex_rd == id_rs1)) || (id_use_rs2 && (ex_rd == id_rs2)));
    assign mem_busy = dmem_req && !dmem_ready;

    // A redirect seen while waiting is not latched; the MEM stage is frozen, so it is re-presented on the ready cycle.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        advance = 1'b0;
        case (state_q)
            RUN: begin
                if (mem_busy) begin
                    state_d = MEM_WAIT;
                    wcnt_d  = 16'd1;
                end else begin
                    advance = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    advance = 1'b1;
                    state_d = RUN;
                    wcnt_d  = 16'd0;
                end else if (wcnt_q == WCNT_LIMIT) begin
                    state_d = ERR;
                end else begin
                    wcnt_d = wcnt_q + 16'd1;
                end
            end
            ERR:     state_d = ERR;
            default: state_d = RUN;
        endcase
    end

    // Outputs are forced low while rst is high, independent of state and inputs.
    always_comb begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_write  = 1'b0;
        ex_mem_write = 1'b0;
        mem_wb_write = 1'b0;
        IFflush      = 1'b0;
        IDflush      = 1'b0;
        EXflush      = 1'b0;
        if (advance && !rst) begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            id_ex_write  = 1'b1;
            ex_mem_write = 1'b1;
            mem_wb_write = 1'b1;
            if (redirect) begin
                IFflush = 1'b1;
                IDflush = 1'b1;
                EXflush = 1'b1;
            end else if (load_use) begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                IDflush     = 1'b1;
            end
        end
    end

    always_comb begin
        mem_timeout_d  = mem_timeout_q || (state_d == ERR);
        stall_cnt_d    = stall_cnt_q;
        redirect_cnt_d = redirect_cnt_q;
        if (!pc_write && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
        if (IFflush && (redirect_cnt_q != CNT_MAX)) begin
            redirect_cnt_d = redirect_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= RUN;
            wcnt_q         <= 16'd0;
            mem_timeout_q  <= 1'b0;
            stall_cnt_q    <= '0;
            redirect_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            wcnt_q         <= wcnt_d;
            mem_timeout_q  <= mem_timeout_d;
            stall_cnt_q    <= stall_cnt_d;
            redirect_cnt_q <= redirect_cnt_d;
        end
    end

    assign mem_timeout  = mem_timeout_q;
    assign stall_cnt    = stall_cnt_q;
    assign redirect_cnt = redirect_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - randomized and directed checks of pipe_hazard_ctrl against a behavioural model
module tb_pipe_hazard_ctrl;
    localparam int TIMEOUT = 4;
    localparam int CW      = 4;
    localparam int CMAX    = 15;
    localparam logic [2:0] OP_SEQ    = 3'd0;
    localparam logic [2:0] OP_BRANCH = 3'd1;
    localparam logic [2:0] OP_JUMP   = 3'd2;
    localparam logic [2:0] OP_JALR   = 3'd3;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    id_rs1, id_rs2, ex_rd;
    logic          id_use_rs1, id_use_rs2, ex_mem_read;
    logic [2:0]    mem_npc_op;
    logic          mem_zero, dmem_req, dmem_ready;
    logic          pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write;
    logic          IFflush, IDflush, EXflush, mem_timeout;
    logic [CW-1:0] stall_cnt, redirect_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // model state: mode 0 = running, 1 = waiting on memory, 2 = timed out
    int m_mode, m_wait, m_stall, m_redir;

    pipe_hazard_ctrl #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .mem_npc_op(mem_npc_op), .mem_zero(mem_zero),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
        .ex_mem_write(ex_mem_write), .mem_wb_write(mem_wb_write),
        .IFflush(IFflush), .IDflush(IDflush), .EXflush(EXflush),
        .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .redirect_cnt(redirect_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_wait  = 0;
        m_stall = 0;
        m_redir = 0;
    endtask

    task automatic set_idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_mem_read = 1'b0; ex_rd = 5'd0; mem_npc_op = OP_SEQ; mem_zero = 1'b0;
        dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    // Inputs are set just after a rising edge; outputs are judged at the falling edge.
    task automatic step();
        bit       redir, lu, adv;
        bit [4:0] e_en;
        bit [2:0] e_fl;
        @(negedge clk);
        if (rst) model_reset();
        redir = (mem_npc_op == OP_BRANCH && mem_zero) || mem_npc_op == OP_JUMP || mem_npc_op == OP_JALR;
        lu = ex_mem_read && ex_rd != 0 &&
             ((id_use_rs1 && ex_rd == id_rs1) || (id_use_rs2 && ex_rd == id_rs2));
        adv = 1'b0;
        if (!rst) begin
            if (m_mode == 0) adv = !(dmem_req && !dmem_ready);
            else if (m_mode == 1) adv = dmem_ready;
        end
        e_en = 5'b0;
        e_fl = 3'b0;
        if (adv) begin
            e_en = 5'b11111;
            if (redir) e_fl = 3'b111;
            else if (lu) begin
                e_en[4] = 1'b0;
                e_en[3] = 1'b0;
                e_fl[1] = 1'b1;
            end
        end
        check_eq("enables", {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write}, 32'(e_en));
        check_eq("flushes", {IFflush, IDflush, EXflush}, 32'(e_fl));
        check_eq("mem_timeout", 32'(mem_timeout), 32'(m_mode == 2));
        check_eq("stall_cnt", 32'(stall_cnt), m_stall);
        check_eq("redirect_cnt", 32'(redirect_cnt), m_redir);
        if (!rst) begin
            if (!e_en[4] && m_stall < CMAX) m_stall++;
            if (e_fl[2] && m_redir < CMAX) m_redir++;
            if (m_mode == 0) begin
                if (!adv) begin m_mode = 1; m_wait = 1; end
            end else if (m_mode == 1) begin
                if (dmem_ready) m_mode = 0;
                else if (m_wait == TIMEOUT) m_mode = 2;
                else m_wait++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic set_load_use();
        set_idle();
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1; id_rs1 = 5'd1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        set_idle();
        rst = 1'b1;
        #1;
        do_reset();

        // load-use stall
        set_load_use();
        step();
        check_eq("lu_stall_cnt", 32'(stall_cnt), 1);

        // taken branch overrides load-use
        mem_npc_op = OP_BRANCH; mem_zero = 1'b1;
        step();
        check_eq("br_redirect_cnt", 32'(redirect_cnt), 1);
        check_eq("br_stall_cnt", 32'(stall_cnt), 1);

        // load into x0 never stalls
        set_idle();
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
        step();
        check_eq("x0_stall_cnt", 32'(stall_cnt), 1);

        // memory wait with deferred jump
        do_reset();
        mem_npc_op = OP_JUMP; dmem_req = 1'b1; dmem_ready = 1'b0;
        repeat (3) step();
        check_eq("wait_no_redirect", 32'(redirect_cnt), 0);
        dmem_ready = 1'b1;
        step();
        set_idle();
        step();
        check_eq("wait_stall_cnt", 32'(stall_cnt), 3);
        check_eq("wait_redirect_cnt", 32'(redirect_cnt), 1);

        // timeout then asynchronous reset from ERR
        do_reset();
        dmem_req = 1'b1; dmem_ready = 1'b0;
        repeat (5) step();
        check_eq("timeout_set", 32'(mem_timeout), 1);
        dmem_ready = 1'b1; mem_npc_op = OP_JALR;
        repeat (2) step();
        check_eq("timeout_sticky", 32'(mem_timeout), 1);
        rst = 1'b1;
        #1;
        check_eq("async_timeout", 32'(mem_timeout), 0);
        check_eq("async_stall", 32'(stall_cnt), 0);
        check_eq("async_pc_write", 32'(pc_write), 0);
        check_eq("async_flush", 32'(IFflush), 0);
        model_reset();
        step();
        rst = 1'b0;
        set_idle();
        step();

        // stall counter saturation
        do_reset();
        set_load_use();
        repeat (20) step();
        check_eq("stall_saturate", 32'(stall_cnt), CMAX);

        // randomized traffic with occasional resets to leave ERR
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 59) == 0);
            id_rs1      = 5'($urandom_range(0, 3));
            id_rs2      = 5'($urandom_range(0, 3));
            ex_rd       = 5'($urandom_range(0, 3));
            id_use_rs1  = 1'($urandom);
            id_use_rs2  = 1'($urandom);
            ex_mem_read = 1'($urandom);
            mem_npc_op  = 3'($urandom_range(0, 7));
            mem_zero    = 1'($urandom);
            dmem_req    = ($urandom_range(0, 3) == 0);
            dmem_ready  = 1'($urandom);
            step();
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, is the number of MEM_WAIT cycles after which the block enters ERR; legal range 1..65535.
REQ-002 Parameter CNT_W, default 16, is the width of both statistics counters.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 id_rs1, id_rs2  in  5 each  source register numbers of the instruction in ID.
REQ-006 id_use_rs1, id_use_rs2  in  1 each  the ID instruction reads rs1 / rs2.
REQ-007 ex_mem_read  in  1  the EX instruction is a load.
REQ-008 ex_rd  in  5  destination register of the EX instruction.
REQ-009 mem_npc_op  in  3  next-PC op of the MEM instruction, encoded per the shared NPC_* definitions header.
REQ-010 mem_zero  in  1  branch condition of the MEM instruction.
REQ-011 dmem_req, dmem_ready  in  1 each  data-memory access pending in MEM / access completes this cycle.
REQ-012 pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write  out  1 each  register load enables.
REQ-013 IFflush, IDflush, EXflush  out  1 each  clear IF/ID, ID/EX and EX/MEM on the next edge.
REQ-014 mem_timeout  out  1  sticky error flag.
REQ-015 stall_cnt, redirect_cnt  out  CNT_W each  statistics counters.

Function
REQ-016 redirect SHALL be 1 when mem_npc_op is NPC_BRANCH with mem_zero=1, or when mem_npc_op is NPC_JUMP or NPC_JALR; otherwise 0.
REQ-017 load_use SHALL be 1 when ex_mem_read=1, ex_rd!=0, and ((id_use_rs1 and ex_rd==id_rs1) or (id_use_rs2 and ex_rd==id_rs2)).
REQ-018 mem_busy SHALL be dmem_req and not dmem_ready.
REQ-019 FSM states: RUN, MEM_WAIT, ERR; 16-bit wait counter wcnt.
REQ-020 The "advance" outputs SHALL be: all five enables 1; no flush, except as set by REQ-021/022.
REQ-021 Redirect under advance: IFflush=IDflush=EXflush=1; load_use SHALL be ignored.
REQ-022 Load-use under advance (no redirect): pc_write=0, if_id_write=0, IDflush=1; the other enables remain 1.
REQ-023 Freeze outputs: all enables 0; all flushes 0.
REQ-024 In RUN with mem_busy=0, the outputs SHALL be advance outputs and the state SHALL stay RUN.
REQ-025 In RUN with mem_busy=1, the outputs SHALL be freeze outputs, the next state SHALL be MEM_WAIT, and wcnt SHALL be set to 1.
REQ-026 In MEM_WAIT with dmem_ready=1, the outputs SHALL be advance outputs, with redirect and load_use evaluated in that cycle, and the next state SHALL be RUN.
REQ-027 In MEM_WAIT with dmem_ready=0, the outputs SHALL be freeze outputs, and wcnt SHALL increment.
REQ-028 In MEM_WAIT with dmem_ready=0 and wcnt==TIMEOUT_CYCLES, the next state SHALL be ERR instead of incrementing wcnt.
REQ-029 In MEM_WAIT, a redirect SHALL be deferred, never dropped: it takes effect only in the cycle dmem_ready=1.
REQ-030 In ERR, the outputs SHALL be freeze outputs and mem_timeout=1; only reset exits ERR.
REQ-031 stall_cnt SHALL increment on each edge where pc_write=0; it saturates at all ones with no wrap.
REQ-032 redirect_cnt SHALL increment on each edge where IFflush=1; it saturates at all ones with no wrap.
REQ-033 All outputs except the counters and mem_timeout SHALL be combinational from state and inputs, with zero-cycle latency.

Reset
REQ-034 While rst=1: state=RUN, wcnt=0, counters=0, mem_timeout=0, all enables 0, all flushes 0, regardless of inputs.
REQ-035 Reset asserted mid-MEM_WAIT or in ERR SHALL abort immediately and discard any deferred redirect.
REQ-036 Normal operation SHALL resume on the first rising edge after rst falls.

Verification
REQ-037 Load-use case:
- Stimulus: RUN, ex_mem_read=1, ex_rd=5, id_rs2=5, id_use_rs2=1, no redirect.
- Response: pc_write=0, if_id_write=0, IDflush=1, id_ex_write=1; stall_cnt +1.
REQ-038 Taken branch plus load-use in the same cycle:
- Stimulus: mem_npc_op=NPC_BRANCH, mem_zero=1, plus load-use.
- Response: all three flushes 1, pc_write=1; redirect_cnt +1.
REQ-039 Load with ex_rd=0:
- Stimulus: ex_mem_read=1, ex_rd=0, matching id_rs1=0.
- Response: no stall, all enables 1.
REQ-040 Memory wait with deferred jump:
- Stimulus: dmem_req=1, dmem_ready=0 for 3 cycles; mem_npc_op=NPC_JUMP throughout; then dmem_ready=1.
- Response: 3 freeze cycles with no flush; flushes only in the ready cycle; then RUN; stall_cnt +3.
REQ-041 Timeout:
- Stimulus: TIMEOUT_CYCLES=4, dmem_ready held 0.
- Response: ERR entered after 4 MEM_WAIT cycles; mem_timeout=1 stays set; asserting rst clears everything within the same cycle (asynchronously).
REQ-042 Counter saturation:
- Stimulus: CNT_W=4, 20 stall cycles.
- Response: stall_cnt stops at 15.
